// File: rtl/exu_iter.sv
// Multi-cycle execute unit: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Operands are captured on accept, and the result is held in DONE until out_ready.
module exu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            use_imm,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [3:0]          op_q, op_d;
  logic [XLEN-1:0]     res_q, res_d;

  logic [XLEN-1:0]     b_in;
  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     alu_res;
  logic                iter_in;
  logic                mul_q;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_trial;
  logic [2*XLEN-1:0]   div_next;

  assign b_in    = use_imm ? imm : src2;
  assign shamt   = b_in[SHW-1:0];
  assign iter_in = (op >= 4'd10) && (op <= 4'd13);
  assign mul_q   = (op_q == 4'd10) || (op_q == 4'd11);

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:  alu_res = src1 + b_in;
      4'd1:  alu_res = src1 - b_in;
      4'd2:  alu_res = {{(XLEN-1){1'b0}}, (src1 < b_in)};
      4'd3:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(b_in))};
      4'd4:  alu_res = src1 & b_in;
      4'd5:  alu_res = src1 | b_in;
      4'd6:  alu_res = src1 ^ b_in;
      4'd7:  alu_res = src1 << shamt;
      4'd8:  alu_res = src1 >> shamt;
      4'd9:  alu_res = $signed(src1) >>> shamt;
      4'd14: alu_res = (src1 == b_in) ? XLEN'(0) : ((src1 > b_in) ? XLEN'(2) : XLEN'(4));
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, b_q};
  assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d  = src1;
          b_d  = b_in;
          op_d = op;
          if (iter_in) begin
            acc_d   = (op[3:2] == 2'b10) ? {{XLEN{1'b0}}, b_in} : {{XLEN{1'b0}}, src1};
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            res_d   = alu_res;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        acc_d = mul_q ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          res_d   = op_q[0] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_exu_iter.sv
// Directed and randomized checks of exu_iter against an arithmetic reference model.
module tb_exu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        use_imm;
  logic [31:0] src1, src2, imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  exu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .use_imm(use_imm), .src1(src1), .src2(src2), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, p;
    int sh;
    ua = 64'(a);
    ub = 64'(b);
    p  = ua * ub;
    sh = int'(b % 32);
    case (o)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return 32'(ua << sh);
      4'd8:  return 32'(ua >> sh);
      4'd9:  return 32'($signed(a) >>> sh);
      4'd10: return 32'(p);
      4'd11: return 32'(p >> 32);
      4'd12: return (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      4'd13: return (ub == 0) ? a : 32'(ua % ub);
      4'd14: return (ua == ub) ? 32'd0 : ((ua > ub) ? 32'd2 : 32'd4);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one op, waits for the result and checks latency and value; optionally completes the handshake.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic ui, input bit release_out);
    int cyc;
    int lat_exp;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    op       = o;
    src1     = a;
    use_imm  = ui;
    src2     = ui ? $urandom : b;
    imm      = ui ? b : $urandom;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op       = 4'($urandom);
    src1     = $urandom;
    src2     = $urandom;
    imm      = $urandom;
    use_imm  = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    lat_exp = (o >= 4'd10 && o <= 4'd13) ? 33 : 1;
    check({tag, "_lat"}, 32'(cyc), 32'(lat_exp));
    check({tag, "_dat"}, out_data, ref_model(o, a, b));
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; op = '0; use_imm = 1'b0;
    src1 = '0; src2 = '0; imm = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("add_imm", 4'd0, 32'd5, 32'd7, 1'b1, 1'b1);
    run_op("sub_wrap", 4'd1, 32'd0, 32'd1, 1'b0, 1'b1);
    run_op("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    run_op("sltu", 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    run_op("cmpu_eq", 4'd14, 32'd3, 32'd3, 1'b0, 1'b1);
    run_op("cmpu_gt", 4'd14, 32'd9, 32'd3, 1'b1, 1'b1);
    run_op("cmpu_lt", 4'd14, 32'd3, 32'd9, 1'b0, 1'b1);
    run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0024, 1'b0, 1'b1);
    run_op("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("divu", 4'd12, 32'd100, 32'd7, 1'b0, 1'b1);
    run_op("remu", 4'd13, 32'd100, 32'd7, 1'b1, 1'b1);
    run_op("divu_z", 4'd12, 32'd5, 32'd0, 1'b0, 1'b1);
    run_op("remu_z", 4'd13, 32'd5, 32'd0, 1'b0, 1'b1);
    run_op("rsvd", 4'd15, 32'h1234_5678, 32'h9, 1'b0, 1'b1);

    // Stall in DONE with out_ready low
    run_op("stall", 4'd6, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 1'b0, 1'b0);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_vld", 32'(out_valid), 32'd1);
      check("stall_dat", out_data, held);
      check("stall_in_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_rdy", 32'(in_ready), 32'd1);
    check("post_hs_vld", 32'(out_valid), 32'd0);
    check("post_hs_dat", out_data, held);
    run_op("after_stall", 4'd0, 32'd40, 32'd2, 1'b0, 1'b1);

    // Asynchronous reset mid-multiply
    @(negedge clk);
    op = 4'd10; src1 = 32'd123; src2 = 32'd456; use_imm = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_rdy", 32'(in_ready), 32'd1);
    check("arst_dat", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("add_after_rst", 4'd0, 32'd1000, 32'd24, 1'b0, 1'b1);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 40));
        1: rb = 32'd0;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
